scoot_world: RTL and testbench



---
 rtl/scoot_world.sv | 106 ++++++++++
 tb/tb_scoot_world.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/scoot_world.sv
// Toroidal food-grid world for the scoot bot: tracks robot position and score,
// applies move requests on each step strobe and drives the look sensors.
module scoot_world #(
  parameter int unsigned        WIDTH     = 10,
  parameter int unsigned        HEIGHT    = 10,
  parameter logic [HEIGHT-1:0]  INIT_COL  = 10'b0010101001,
  parameter int unsigned        START_X   = 5,
  parameter int unsigned        START_Y   = 5,
  parameter int unsigned        NUM_STEPS = 100
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               step,
  input  logic                               mUp,
  input  logic                               mRight,
  input  logic                               mDown,
  input  logic                               mLeft,
  output logic                               lUp,
  output logic                               lRight,
  output logic                               lDown,
  output logic                               lLeft,
  output logic [$clog2(WIDTH)-1:0]           pos_x,
  output logic [$clog2(HEIGHT)-1:0]          pos_y,
  output logic [$clog2(WIDTH*HEIGHT+1)-1:0]  score,
  output logic                               pickup,
  output logic                               busy,
  output logic                               done
);

  localparam int unsigned XW  = $clog2(WIDTH);
  localparam int unsigned YW  = $clog2(HEIGHT);
  localparam int unsigned SCW = $clog2(WIDTH*HEIGHT+1);
  localparam int unsigned SW  = $clog2(NUM_STEPS+1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [HEIGHT-1:0] grid [WIDTH];
  logic [SW-1:0]     stepCount;
  logic [XW-1:0]     xInc, xDec, xNext;
  logic [YW-1:0]     yInc, yDec, yNext;
  logic              reload;
  logic              doStep;

  always_comb begin
    xInc = (pos_x == XW'(WIDTH-1))  ? '0 : pos_x + XW'(1);
    xDec = (pos_x == '0) ? XW'(WIDTH-1)  : pos_x - XW'(1);
    yInc = (pos_y == YW'(HEIGHT-1)) ? '0 : pos_y + YW'(1);
    yDec = (pos_y == '0) ? YW'(HEIGHT-1) : pos_y - YW'(1);
    xNext = pos_x;
    if (mRight && !mLeft)      xNext = xInc;
    else if (mLeft && !mRight) xNext = xDec;
    yNext = pos_y;
    if (mUp && !mDown)         yNext = yInc;
    else if (mDown && !mUp)    yNext = yDec;
  end

  // Reset and a run-starting start share one world-reload path.
  assign reload = reset || (start && (state != RUN));
  assign doStep = (state == RUN) && step;

  always_ff @(posedge clock) begin
    pickup <= 1'b0;
    if (reload) begin
      for (int unsigned i = 0; i < WIDTH; i++) grid[i] <= INIT_COL;
      pos_x     <= XW'(START_X);
      pos_y     <= YW'(START_Y);
      score     <= '0;
      stepCount <= '0;
    end else if (doStep) begin
      if (grid[pos_x][pos_y]) begin
        grid[pos_x][pos_y] <= 1'b0;
        score              <= score + SCW'(1);
        pickup             <= 1'b1;
      end
      pos_x     <= xNext;
      pos_y     <= yNext;
      stepCount <= stepCount + SW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state <= RUN;
        RUN:     if (step && (stepCount == SW'(NUM_STEPS-1))) state <= DONE;
        DONE:    if (start) state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  assign lUp    = grid[pos_x][yInc];
  assign lDown  = grid[pos_x][yDec];
  assign lRight = grid[xInc][pos_y];
  assign lLeft  = grid[xDec][pos_y];

endmodule

// File: tb/tb_scoot_world.sv
// Directed bench for scoot_world: default-parameter instance (A) plus a
// NUM_STEPS=4 instance (B) sharing clock and move inputs.
module tb_scoot_world;

  logic clock = 1'b0;
  logic resetA = 1'b1, startA = 1'b0, stepA = 1'b0;
  logic resetB = 1'b1, startB = 1'b0, stepB = 1'b0;
  logic mUp = 1'b0, mRight = 1'b0, mDown = 1'b0, mLeft = 1'b0;

  logic       lUpA, lRightA, lDownA, lLeftA, pickupA, busyA, doneA;
  logic [3:0] posXA, posYA;
  logic [6:0] scoreA;
  logic       lUpB, lRightB, lDownB, lLeftB, pickupB, busyB, doneB;
  logic [3:0] posXB, posYB;
  logic [6:0] scoreB;

  int checks = 0;
  int passes = 0;

  always #5 clock = ~clock;

  scoot_world dutA (
    .clock(clock), .reset(resetA), .start(startA), .step(stepA),
    .mUp(mUp), .mRight(mRight), .mDown(mDown), .mLeft(mLeft),
    .lUp(lUpA), .lRight(lRightA), .lDown(lDownA), .lLeft(lLeftA),
    .pos_x(posXA), .pos_y(posYA), .score(scoreA),
    .pickup(pickupA), .busy(busyA), .done(doneA)
  );

  scoot_world #(.NUM_STEPS(4)) dutB (
    .clock(clock), .reset(resetB), .start(startB), .step(stepB),
    .mUp(mUp), .mRight(mRight), .mDown(mDown), .mLeft(mLeft),
    .lUp(lUpB), .lRight(lRightB), .lDown(lDownB), .lLeft(lLeftB),
    .pos_x(posXB), .pos_y(posYB), .score(scoreB),
    .pickup(pickupB), .busy(busyB), .done(doneB)
  );

  // Inputs change on the falling edge; outputs are checked on the next falling edge.
  task automatic stepA1(input logic u, input logic r, input logic d, input logic l);
    @(negedge clock);
    stepA = 1'b1; mUp = u; mRight = r; mDown = d; mLeft = l;
    @(negedge clock);
    stepA = 1'b0; mUp = 1'b0; mRight = 1'b0; mDown = 1'b0; mLeft = 1'b0;
  endtask

  task automatic stepB1(input logic u, input logic r, input logic d, input logic l);
    @(negedge clock);
    stepB = 1'b1; mUp = u; mRight = r; mDown = d; mLeft = l;
    @(negedge clock);
    stepB = 1'b0; mUp = 1'b0; mRight = 1'b0; mDown = 1'b0; mLeft = 1'b0;
  endtask

  task automatic startA1();
    @(negedge clock); startA = 1'b1;
    @(negedge clock); startA = 1'b0;
  endtask

  task automatic startB1();
    @(negedge clock); startB = 1'b1;
    @(negedge clock); startB = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    resetA = 1'b0; resetB = 1'b0;
    checks++; if ({posXA, posYA} !== {4'd5, 4'd5}) $display("FAIL reset_pos got (%0d,%0d) want (5,5)", posXA, posYA); else passes++;
    checks++; if (scoreA !== 7'd0) $display("FAIL reset_score got %0d want 0", scoreA); else passes++;
    checks++; if ({busyA, doneA, pickupA} !== 3'b000) $display("FAIL reset_flags got busy/done/pickup %b want 000", {busyA, doneA, pickupA}); else passes++;
    checks++; if ({lUpA, lRightA, lDownA, lLeftA} !== 4'b0101) $display("FAIL reset_sensors got %b want 0101", {lUpA, lRightA, lDownA, lLeftA}); else passes++;
    stepA1(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if ({posXA, scoreA} !== {4'd5, 7'd0}) $display("FAIL idle_step_ignored got x=%0d score=%0d want x=5 score=0", posXA, scoreA); else passes++;
  endtask

  task automatic test_collect();
    startA1();
    checks++; if (busyA !== 1'b1) $display("FAIL start_busy got %b want 1", busyA); else passes++;
    stepA1(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if ({posXA, posYA} !== {4'd6, 4'd5}) $display("FAIL collect_pos got (%0d,%0d) want (6,5)", posXA, posYA); else passes++;
    checks++; if (scoreA !== 7'd1) $display("FAIL collect_score got %0d want 1", scoreA); else passes++;
    checks++; if (pickupA !== 1'b1) $display("FAIL collect_pickup got %b want 1", pickupA); else passes++;
    checks++; if (lLeftA !== 1'b0) $display("FAIL collect_cleared_lLeft got %b want 0", lLeftA); else passes++;
    @(negedge clock);
    checks++; if (pickupA !== 1'b0) $display("FAIL pickup_one_cycle got %b want 0", pickupA); else passes++;
  endtask

  task automatic test_wrap();
    repeat (3) stepA1(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if ({posXA, scoreA} !== {4'd9, 7'd4}) $display("FAIL at_x9 got x=%0d score=%0d want x=9 score=4", posXA, scoreA); else passes++;
    checks++; if (lRightA !== 1'b1) $display("FAIL wrap_lRight got %b want 1", lRightA); else passes++;
    stepA1(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if ({posXA, posYA, scoreA} !== {4'd0, 4'd5, 7'd5}) $display("FAIL wrap_x got (%0d,%0d) score=%0d want (0,5) score=5", posXA, posYA, scoreA); else passes++;
    stepA1(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if ({posYA, lUpA, lDownA} !== {4'd4, 1'b0, 1'b1}) $display("FAIL at_y4 got y=%0d lUp=%b lDown=%b want y=4 lUp=0 lDown=1", posYA, lUpA, lDownA); else passes++;
    repeat (4) stepA1(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if ({posYA, scoreA} !== {4'd0, 7'd7}) $display("FAIL at_y0 got y=%0d score=%0d want y=0 score=7", posYA, scoreA); else passes++;
    stepA1(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if ({posXA, posYA, scoreA, pickupA} !== {4'd0, 4'd9, 7'd8, 1'b1}) $display("FAIL wrap_y got (%0d,%0d) score=%0d pickup=%b want (0,9) score=8 pickup=1", posXA, posYA, scoreA, pickupA); else passes++;
    checks++; if ({lUpA, lDownA, lLeftA} !== 3'b000) $display("FAIL sensors_0_9 got lUp/lDown/lLeft %b want 000", {lUpA, lDownA, lLeftA}); else passes++;
    stepA1(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if ({posYA, scoreA, pickupA} !== {4'd0, 7'd8, 1'b0}) $display("FAIL wrap_y_up got y=%0d score=%0d pickup=%b want y=0 score=8 pickup=0", posYA, scoreA, pickupA); else passes++;
    stepA1(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if ({posXA, posYA} !== {4'd9, 4'd0}) $display("FAIL wrap_x_left got (%0d,%0d) want (9,0)", posXA, posYA); else passes++;
    checks++; if ({lLeftA, lRightA} !== 2'b10) $display("FAIL sensors_9_0 got lLeft/lRight %b want 10", {lLeftA, lRightA}); else passes++;
  endtask

  task automatic test_cancel();
    stepA1(1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if ({posXA, posYA, scoreA, pickupA} !== {4'd9, 4'd0, 7'd9, 1'b1}) $display("FAIL cancel_ud got (%0d,%0d) score=%0d pickup=%b want (9,0) score=9 pickup=1", posXA, posYA, scoreA, pickupA); else passes++;
    stepA1(1'b0, 1'b1, 1'b0, 1'b1);
    checks++; if ({posXA, posYA, scoreA, pickupA} !== {4'd9, 4'd0, 7'd9, 1'b0}) $display("FAIL cancel_lr_revisit got (%0d,%0d) score=%0d pickup=%b want (9,0) score=9 pickup=0", posXA, posYA, scoreA, pickupA); else passes++;
    stepA1(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if ({posXA, posYA, scoreA, busyA} !== {4'd9, 4'd0, 7'd9, 1'b1}) $display("FAIL idle_move got (%0d,%0d) score=%0d busy=%b want (9,0) score=9 busy=1", posXA, posYA, scoreA, busyA); else passes++;
  endtask

  task automatic test_num_steps();
    startB1();
    stepB1(1'b0, 1'b1, 1'b0, 1'b0);
    stepB1(1'b0, 1'b1, 1'b0, 1'b0);
    stepB1(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if ({busyB, doneB} !== 2'b10) $display("FAIL steps3_flags got busy/done %b want 10", {busyB, doneB}); else passes++;
    stepB1(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if ({posXB, posYB, scoreB} !== {4'd7, 4'd7, 7'd3}) $display("FAIL steps4_state got (%0d,%0d) score=%0d want (7,7) score=3", posXB, posYB, scoreB); else passes++;
    checks++; if ({busyB, doneB} !== 2'b01) $display("FAIL steps4_done got busy/done %b want 01", {busyB, doneB}); else passes++;
    stepB1(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if ({posXB, posYB, scoreB, pickupB} !== {4'd7, 4'd7, 7'd3, 1'b0}) $display("FAIL step5_ignored got (%0d,%0d) score=%0d pickup=%b want (7,7) score=3 pickup=0", posXB, posYB, scoreB, pickupB); else passes++;
    startB1();
    checks++; if ({posXB, posYB, scoreB, busyB, doneB} !== {4'd5, 4'd5, 7'd0, 1'b1, 1'b0}) $display("FAIL restart got (%0d,%0d) score=%0d busy/done=%b%b want (5,5) score=0 busy/done=10", posXB, posYB, scoreB, busyB, doneB); else passes++;
    stepB1(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if ({scoreB, pickupB} !== {7'd1, 1'b1}) $display("FAIL restart_reload got score=%0d pickup=%b want score=1 pickup=1", scoreB, pickupB); else passes++;
  endtask

  task automatic test_reset_midrun();
    @(negedge clock); resetA = 1'b1;
    @(negedge clock); resetA = 1'b0;
    startA1();
    stepA1(1'b0, 1'b1, 1'b0, 1'b0);
    stepA1(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if ({posXA, scoreA} !== {4'd7, 7'd2}) $display("FAIL pre_reset got x=%0d score=%0d want x=7 score=2", posXA, scoreA); else passes++;
    @(negedge clock);
    resetA = 1'b1; stepA = 1'b1; mRight = 1'b1;
    @(negedge clock);
    resetA = 1'b0; stepA = 1'b0; mRight = 1'b0;
    checks++; if ({posXA, posYA, scoreA} !== {4'd5, 4'd5, 7'd0}) $display("FAIL midrun_reset got (%0d,%0d) score=%0d want (5,5) score=0", posXA, posYA, scoreA); else passes++;
    checks++; if ({busyA, doneA, pickupA} !== 3'b000) $display("FAIL midrun_reset_flags got busy/done/pickup %b want 000", {busyA, doneA, pickupA}); else passes++;
    checks++; if ({lUpA, lRightA, lDownA, lLeftA} !== 4'b0101) $display("FAIL midrun_reset_sensors got %b want 0101", {lUpA, lRightA, lDownA, lLeftA}); else passes++;
    stepA1(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if ({posXA, scoreA, busyA} !== {4'd5, 7'd0, 1'b0}) $display("FAIL post_reset_step got x=%0d score=%0d busy=%b want x=5 score=0 busy=0", posXA, scoreA, busyA); else passes++;
  endtask

  initial begin
    test_reset();
    test_collect();
    test_wrap();
    test_cancel();
    test_num_steps();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
